// File: rtl/cpu_bus_unit.sv
// cpu_bus_unit
// Multi-cycle bus interface unit. Arbitrates instruction fetch and load/store
// requests onto one external valid/ready bus. The unit supports variable wait
// states, per-byte lane enables, load extension, misalignment detection and a
// wait-state timeout.
//
// Ports
//   clk, reset                   clock (rising edge), async active-high reset
//   fetch_req/fetch_addr         fetch request, held until fetch_ack
//   fetch_ack/instr/err          one-cycle completion pulse with result
//   mem_req/we/size/unsigned     load/store request, held until mem_ack
//   mem_addr/mem_wdata           data address, right-aligned store data
//   mem_ack/rdata/err            one-cycle completion pulse with result
//   bus_valid/we/addr/be/wdata   external bus request (addr lane bits zero)
//   bus_rdata/bus_ready          external bus response
//   busy                         a bus cycle is in progress
module cpu_bus_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_req,
    input  logic [ADDR_W-1:0]   fetch_addr,
    output logic                fetch_ack,
    output logic [31:0]         fetch_instr,
    output logic                fetch_err,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [1:0]          mem_size,
    input  logic                mem_unsigned,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_ack,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_err,
    output logic                bus_valid,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ready,
    output logic                busy
);

    localparam int NB = DATA_W / 8;
    localparam int LW = $clog2(NB);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Value the wait counter holds on the edge that would take it to TIMEOUT.
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;

    logic                valid_d, we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [NB-1:0]       be_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                fack_d, ferr_d, mack_d, merr_d;
    logic [31:0]         finstr_d;
    logic [DATA_W-1:0]   mrdata_d;

    logic                mem_bad, fetch_bad, timeout_hit;
    logic [LW-1:0]       mem_lane, fetch_lane;

    function automatic logic [NB-1:0] lane_enables(input logic [1:0] size,
                                                   input logic [LW-1:0] lane);
        logic [NB-1:0] base;
        case (size)
            2'd0:    base = NB'(1);
            2'd1:    base = NB'(3);
            2'd2:    base = NB'(15);
            default: base = '1;
        endcase
        return base << lane;
    endfunction

    // Shift the addressed bytes down to bit 0, keep the access size, then
    // sign- or zero-extend to the full data width.
    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] raw,
                                                      input logic [LW-1:0]     lane,
                                                      input logic [1:0]        size,
                                                      input logic              zero_ext);
        logic [DATA_W-1:0] shifted;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        shifted = raw >> {lane, 3'b000};
        b = shifted[7:0];
        h = shifted[15:0];
        w = shifted[31:0];
        case (size)
            2'd0: begin
                if (zero_ext) return DATA_W'(shifted[7:0]);
                else          return DATA_W'(b);
            end
            2'd1: begin
                if (zero_ext) return DATA_W'(shifted[15:0]);
                else          return DATA_W'(h);
            end
            2'd2: begin
                if (zero_ext) return DATA_W'(shifted[31:0]);
                else          return DATA_W'(w);
            end
            default: return shifted;
        endcase
    endfunction

    function automatic logic [31:0] select_word(input logic [DATA_W-1:0] raw,
                                                input logic [LW-1:0]     lane);
        logic [DATA_W-1:0] shifted;
        shifted = raw >> {lane, 3'b000};
        return shifted[31:0];
    endfunction

    assign mem_lane    = mem_addr[LW-1:0];
    assign fetch_lane  = fetch_addr[LW-1:0];
    assign fetch_bad   = |fetch_addr[1:0];
    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);
    assign busy        = (state_q != IDLE);

    // A dword access is only legal on a 64-bit bus.
    always_comb begin
        case (mem_size)
            2'd0:    mem_bad = 1'b0;
            2'd1:    mem_bad = mem_addr[0];
            2'd2:    mem_bad = |mem_addr[1:0];
            default: mem_bad = (DATA_W == 32) ? 1'b1 : |mem_addr[2:0];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lane_d   = lane_q;
        size_d   = size_q;
        uns_d    = uns_q;
        valid_d  = bus_valid;
        we_d     = bus_we;
        addr_d   = bus_addr;
        be_d     = bus_be;
        wdata_d  = bus_wdata;
        fack_d   = 1'b0;
        ferr_d   = 1'b0;
        finstr_d = '0;
        mack_d   = 1'b0;
        merr_d   = 1'b0;
        mrdata_d = '0;

        case (state_q)
            IDLE: begin
                // The cycle carrying an ack is dead time, so a requester that
                // keeps its request high is restarted one cycle later.
                if (!fetch_ack && !mem_ack) begin
                    if (mem_req) begin
                        if (mem_bad) begin
                            mack_d = 1'b1;
                            merr_d = 1'b1;
                        end else begin
                            state_d = DATA;
                            cnt_d   = '0;
                            valid_d = 1'b1;
                            we_d    = mem_we;
                            addr_d  = {mem_addr[ADDR_W-1:LW], {LW{1'b0}}};
                            be_d    = lane_enables(mem_size, mem_lane);
                            wdata_d = mem_wdata << {mem_lane, 3'b000};
                            lane_d  = mem_lane;
                            size_d  = mem_size;
                            uns_d   = mem_unsigned;
                        end
                    end else if (fetch_req) begin
                        if (fetch_bad) begin
                            fack_d = 1'b1;
                            ferr_d = 1'b1;
                        end else begin
                            state_d = FETCH;
                            cnt_d   = '0;
                            valid_d = 1'b1;
                            we_d    = 1'b0;
                            addr_d  = {fetch_addr[ADDR_W-1:LW], {LW{1'b0}}};
                            be_d    = lane_enables(2'd2, fetch_lane);
                            wdata_d = '0;
                            lane_d  = fetch_lane;
                            size_d  = 2'd2;
                            uns_d   = 1'b0;
                        end
                    end
                end
            end

            FETCH: begin
                // Ready wins over a timeout reached on the same edge.
                if (bus_ready) begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    fack_d   = 1'b1;
                    finstr_d = select_word(bus_rdata, lane_q);
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    fack_d  = 1'b1;
                    ferr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (bus_ready) begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    mack_d   = 1'b1;
                    mrdata_d = bus_we ? '0 : extend_load(bus_rdata, lane_q, size_q, uns_q);
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    mack_d  = 1'b1;
                    merr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lane_q      <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            bus_valid   <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
            fetch_ack   <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_instr <= '0;
            mem_ack     <= 1'b0;
            mem_err     <= 1'b0;
            mem_rdata   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            bus_valid   <= valid_d;
            bus_we      <= we_d;
            bus_addr    <= addr_d;
            bus_be      <= be_d;
            bus_wdata   <= wdata_d;
            fetch_ack   <= fack_d;
            fetch_err   <= ferr_d;
            fetch_instr <= finstr_d;
            mem_ack     <= mack_d;
            mem_err     <= merr_d;
            mem_rdata   <= mrdata_d;
        end
    end

endmodule
